fc_node_seq: RTL and testbench

Parametrised sequential fully-connected neuron. It walks a configurable number of inputs one per clock and multiply-accumulates pixel/activation × weight in signed fixed point. It then adds the node bias, saturates, optionally applies ReLU and registers the result with a done pulse. It is the clocked successor to the single-node combinational FC datapath. It sits between the pixel/weight/bias ROMs and the next layer, with one instance per node or one time-shared instance driven by a layer sequencer.

---
 rtl/fc_pkg.sv | 52 +++++
 rtl/fc_mac_unit.sv | 54 +++++
 rtl/fc_node_seq.sv | 148 ++++++++++++++
 tb/tb_fc_node_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fc_pkg
//  Description : Shared definitions for the fully-connected neuron family:
//                default Q-format widths, the sequencer state encoding and
//                the accumulator-to-output saturation helper.
//  Revision    : 1.0  initial release
// ============================================================================
package fc_pkg;

  localparam int FC_DATA_W = 32;   // default data word width
  localparam int FC_FRAC_W = 16;   // default fractional bits (Q16.16)

  // Saturation helper operates on fixed maximum widths so it can serve any
  // instance with ACC_W+1 < SAT_IN_W and DATA_W <= SAT_OUT_W.
  localparam int SAT_IN_W  = 128;
  localparam int SAT_OUT_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    BIAS = 2'd2
  } fc_state_t;

  // Clips a signed value into a dw-bit signed range.
  // Returns {clipped_flag, value}; value is sign-correct in its low dw bits.
  function automatic logic [SAT_OUT_W:0] saturate(
    input logic signed [SAT_IN_W-1:0] val,
    input int                         dw
  );
    logic signed [SAT_IN_W-1:0] one;
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    logic [SAT_OUT_W:0]         res;
    one = 1;
    hi  = (one <<< (dw - 1)) - one;
    lo  = -(one <<< (dw - 1));
    res = '0;
    if (val > hi) begin
      res[SAT_OUT_W]     = 1'b1;
      res[SAT_OUT_W-1:0] = hi[SAT_OUT_W-1:0];
    end else if (val < lo) begin
      res[SAT_OUT_W]     = 1'b1;
      res[SAT_OUT_W-1:0] = lo[SAT_OUT_W-1:0];
    end else begin
      res[SAT_OUT_W-1:0] = val[SAT_OUT_W-1:0];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fc_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fc_mac_unit
//  Description : Signed fixed-point multiply-accumulate lane.
//                acc <= acc + ((a * b) >>> FRAC_W) when enabled.
//  Ports       : clk, rst   - clock / synchronous active-high reset
//                i_clear    - zero the accumulator (wins over i_en)
//                i_en       - accumulate this cycle
//                i_a, i_b   - signed operands
//                o_acc      - accumulator register
//  Revision    : 1.0  initial release
// ============================================================================
module fc_mac_unit #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int ACC_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_acc
);

  logic signed [DATA_W-1:0]   w_a;
  logic signed [DATA_W-1:0]   w_b;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [2*DATA_W-1:0] w_shift;
  logic signed [ACC_W-1:0]    w_inc;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_a     = i_a;
  assign w_b     = i_b;
  // Full-width signed product; arithmetic shift rounds toward -inf.
  assign w_prod  = w_a * w_b;
  assign w_shift = w_prod >>> FRAC_W;
  assign w_inc   = ACC_W'(w_shift);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_inc;
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/fc_node_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fc_node_seq
//  Description : Sequential fully-connected neuron. Walks N_IN inputs one per
//                clock through a MAC lane, adds the bias, saturates to DATA_W,
//                optionally applies ReLU and registers the result with a
//                one-cycle done pulse. Latency N_IN+2 cycles.
//  Ports       : clk, reset        - clock / synchronous active-high reset
//                start, relu_en    - request and mode (sampled in IDLE)
//                in_idx            - ROM address for px_data / wt_data
//                px_data, wt_data  - combinational ROM data at in_idx
//                bias_data         - node bias, stable while busy
//                busy, done        - status; done marks node_out valid
//                node_out, sat     - registered result and clip flag
//  Revision    : 1.0  initial release
// ============================================================================
module fc_node_seq
  import fc_pkg::*;
#(
  parameter int N_IN   = 784,
  parameter int DATA_W = FC_DATA_W,
  parameter int FRAC_W = FC_FRAC_W,
  parameter int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int ACC_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              relu_en,
  output logic [IDX_W-1:0]  in_idx,
  input  logic [DATA_W-1:0] px_data,
  input  logic [DATA_W-1:0] wt_data,
  input  logic [DATA_W-1:0] bias_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] node_out,
  output logic              sat
);

  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(N_IN - 1);

  fc_state_t           r_state;
  fc_state_t           w_next;
  logic                w_acc_clr;
  logic                w_acc_en;
  logic [IDX_W-1:0]    r_idx;
  logic                r_relu;
  logic                r_done;
  logic [DATA_W-1:0]   r_out;
  logic                r_sat;

  logic [ACC_W-1:0]             w_acc_raw;
  logic signed [ACC_W-1:0]      w_acc;
  logic signed [DATA_W-1:0]     w_bias;
  logic signed [ACC_W:0]        w_sum;
  logic signed [SAT_IN_W-1:0]   w_sum_ext;
  logic [SAT_OUT_W:0]           w_sat_pkt;
  logic                         w_sat_flag;
  logic [DATA_W-1:0]            w_sat_val;
  logic [DATA_W-1:0]            w_res;

  fc_mac_unit #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (reset),
    .i_clear (w_acc_clr),
    .i_en    (w_acc_en),
    .i_a     (px_data),
    .i_b     (wt_data),
    .o_acc   (w_acc_raw)
  );

  // Bias add is one bit wider than the accumulator so the sum itself can
  // never wrap before it reaches the saturator.
  assign w_acc      = w_acc_raw;
  assign w_bias     = bias_data;
  assign w_sum      = (ACC_W+1)'(w_acc) + (ACC_W+1)'(w_bias);
  assign w_sum_ext  = SAT_IN_W'(w_sum);
  assign w_sat_pkt  = saturate(w_sum_ext, DATA_W);
  assign w_sat_flag = w_sat_pkt[SAT_OUT_W];
  assign w_sat_val  = DATA_W'(w_sat_pkt[SAT_OUT_W-1:0]);
  // ReLU acts after clipping; the clip flag still reports the saturation.
  assign w_res      = (r_relu && w_sat_val[DATA_W-1]) ? '0 : w_sat_val;

  always_comb begin
    w_next    = r_state;
    w_acc_clr = 1'b0;
    w_acc_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_acc_clr = 1'b1;
          w_next    = MAC;
        end
      end
      MAC: begin
        w_acc_en = 1'b1;
        if (r_idx == C_LAST) begin
          w_next = BIAS;
        end
      end
      BIAS: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_relu  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == BIAS);
      if ((r_state == IDLE) && start) begin
        r_relu <= relu_en;
      end
      // Index parks at zero outside MAC and never steps past the last input.
      if (r_state == MAC) begin
        r_idx <= (r_idx == C_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_idx <= '0;
      end
      if (r_state == BIAS) begin
        r_out <= w_res;
        r_sat <= w_sat_flag;
      end
    end
  end

  assign in_idx   = r_idx;
  assign busy     = (r_state == MAC) || (r_state == BIAS);
  assign done     = r_done;
  assign node_out = r_out;
  assign sat      = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_fc_node_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc_node_seq
//  Description : Scoreboard bench for fc_node_seq. A 4-input instance gets
//                directed and random nodes; a default 784-input instance
//                covers the long-latency case and the index walk.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fc_node_seq;

  localparam int N4 = 4;
  localparam int NB = 784;

  typedef struct {
    logic [31:0] out;
    logic        sat;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- 4-input instance ----------------
  logic               start4, relu4;
  logic [1:0]         idx4;
  logic [31:0]        px4, wt4, bias4, out4;
  logic               busy4, done4, sat4;
  logic signed [31:0] px_mem4 [N4];
  logic signed [31:0] wt_mem4 [N4];
  assign px4 = px_mem4[idx4];
  assign wt4 = wt_mem4[idx4];

  fc_node_seq #(.N_IN(N4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .relu_en(relu4),
    .in_idx(idx4), .px_data(px4), .wt_data(wt4), .bias_data(bias4),
    .busy(busy4), .done(done4), .node_out(out4), .sat(sat4)
  );

  // ---------------- default 784-input instance ----------------
  logic               startB;
  logic [9:0]         idxB;
  logic [31:0]        pxB, wtB, biasB, outB;
  logic               busyB, doneB, satB;
  logic signed [31:0] wt_memB [NB];
  assign pxB   = 32'h0;
  assign biasB = 32'h0000_1000;
  assign wtB   = (idxB < 10'(NB)) ? wt_memB[idxB] : 32'h0;

  fc_node_seq dutB (
    .clk(clk), .reset(reset), .start(startB), .relu_en(1'b0),
    .in_idx(idxB), .px_data(pxB), .wt_data(wtB), .bias_data(biasB),
    .busy(busyB), .done(doneB), .node_out(outB), .sat(satB)
  );

  exp_t q4[$];
  exp_t qB[$];
  int   bstart = -1;
  int   bbad   = 0;

  // Reference: sum of shifted products, plus bias, clipped, then ReLU.
  function automatic exp_t model4(input logic relu, input logic signed [31:0] bias, input int t);
    exp_t   e;
    longint acc;
    longint s;
    acc = 0;
    for (int k = 0; k < N4; k++)
      acc += (longint'(px_mem4[k]) * longint'(wt_mem4[k])) >>> 16;
    s = acc + longint'(bias);
    e.sat = 1'b0;
    if (s > 64'sd2147483647) begin
      e.out = 32'h7FFF_FFFF; e.sat = 1'b1;
    end else if (s < -64'sd2147483648) begin
      e.out = 32'h8000_0000; e.sat = 1'b1;
    end else begin
      e.out = s[31:0];
    end
    if (relu && e.out[31]) e.out = 32'h0;
    e.done_cyc = t + N4 + 2;
    return e;
  endfunction

  task automatic sb_check(input string nm, input logic [31:0] got, input logic gsat, input exp_t e);
    checks++;
    if (got !== e.out || gsat !== e.sat || cyc != e.done_cyc) begin
      errors++;
      $display("FAIL %s: got out=%h sat=%b cyc=%0d, expected out=%h sat=%b cyc=%0d",
               nm, got, gsat, cyc, e.out, e.sat, e.done_cyc);
    end
  endtask

  // Monitor: compares every done pulse against the head of its queue and
  // flags any expected done that never arrived.
  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4_unexpected_done: got done at cyc=%0d, expected none", cyc);
      end else begin
        sb_check("dut4_result", out4, sat4, q4.pop_front());
      end
    end else if (q4.size() != 0 && cyc > q4[0].done_cyc) begin
      checks++; errors++;
      $display("FAIL dut4_missing_done: got no done, expected at cyc=%0d", q4[0].done_cyc);
      void'(q4.pop_front());
    end
    if (doneB) begin
      if (qB.size() == 0) begin
        checks++; errors++;
        $display("FAIL dutB_unexpected_done: got done at cyc=%0d, expected none", cyc);
      end else begin
        sb_check("dutB_result", outB, satB, qB.pop_front());
      end
    end else if (qB.size() != 0 && cyc > qB[0].done_cyc) begin
      checks++; errors++;
      $display("FAIL dutB_missing_done: got no done, expected at cyc=%0d", qB[0].done_cyc);
      void'(qB.pop_front());
    end
    // Index walk for the long node: in_idx must equal k at T+1+k.
    if (bstart >= 0 && cyc >= bstart + 1 && cyc <= bstart + NB) begin
      if (idxB !== 10'(cyc - bstart - 1)) bbad++;
      if (cyc == bstart + NB) begin
        checks++;
        if (bbad != 0) begin
          errors++;
          $display("FAIL dutB_idx_walk: got %0d wrong index cycles, expected 0", bbad);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill4(input logic [31:0] px, input logic [31:0] wt);
    for (int k = 0; k < N4; k++) begin
      px_mem4[k] = px;
      wt_mem4[k] = wt;
    end
  endtask

  // Drives start for one cycle; expectation is queued only when a result
  // must come out of this request.
  task automatic issue4(input logic relu, input logic [31:0] bias, input bit expect_done);
    relu4  = relu;
    bias4  = bias;
    start4 = 1'b1;
    if (expect_done) q4.push_back(model4(relu, bias, cyc));
    tick();
    start4 = 1'b0;
  endtask

  // From cycle T+1 advance to cycle T+N4+2+gap (gap=0 is the done cycle).
  task automatic wait4(input int gap);
    repeat (N4 + 1 + gap) tick();
  endtask

  function automatic logic [31:0] rnd_word();
    int v;
    if ($urandom_range(0, 3) == 0) return $urandom;
    v = int'($urandom_range(0, 32'h7FFFF)) - 32'h40000;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    start4 = 1'b0; relu4 = 1'b0; bias4 = 32'h0;
    startB = 1'b0;
    fill4(32'h0, 32'h0);
    for (int k = 0; k < NB; k++) wt_memB[k] = $urandom;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_busy",  busy4, 0);
    chk("reset_done",  done4, 0);
    chk("reset_out",   out4,  0);
    chk("reset_sat",   sat4,  0);
    chk("reset_idx",   idx4,  0);
    chk("reset_busyB", busyB, 0);

    // Directed nodes
    fill4(32'h0001_0000, 32'h0000_8000); issue4(1'b1, 32'h0000_4000, 1'b1); wait4(1);
    fill4(32'h0001_0000, 32'hFFFF_8000); issue4(1'b1, 32'h0,         1'b1); wait4(1);
    issue4(1'b0, 32'h0, 1'b1); wait4(1);
    fill4(32'h7FFF_0000, 32'h7FFF_0000); issue4(1'b0, 32'h0, 1'b1); wait4(1);
    fill4(32'h7FFF_0000, 32'h8001_0000); issue4(1'b0, 32'h0, 1'b1); wait4(1);

    // Reset in the middle of MAC drops the node entirely.
    fill4(32'h0001_0000, 32'h0000_8000);
    issue4(1'b1, 32'h0000_4000, 1'b0);   // now T+1
    tick();                              // T+2
    tick();                              // T+3
    reset = 1'b1;
    tick();                              // T+4
    reset = 1'b0;
    chk("midreset_busy", busy4, 0);
    chk("midreset_idx",  idx4,  0);
    chk("midreset_out",  out4,  0);
    chk("midreset_sat",  sat4,  0);
    chk("midreset_done", done4, 0);
    repeat (8) tick();
    issue4(1'b1, 32'h0000_4000, 1'b1); wait4(1);

    // Starts while busy are ignored; start on the done cycle is taken.
    issue4(1'b1, 32'h0000_4000, 1'b1);   // T+1
    tick();                              // T+2
    start4 = 1'b1; tick(); start4 = 1'b0; // T+3
    tick();                              // T+4
    start4 = 1'b1; tick(); start4 = 1'b0; // T+5
    tick();                              // T+6 (done cycle)
    issue4(1'b0, 32'h0000_4000, 1'b1);   // second done at T+12
    wait4(1);

    // Random nodes, random gaps including back-to-back on done cycle.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < N4; k++) begin
        px_mem4[k] = rnd_word();
        wt_mem4[k] = rnd_word();
      end
      issue4(1'($urandom_range(0, 1)), rnd_word(), 1'b1);
      wait4(int'($urandom_range(0, 2)));
    end
    repeat (10) tick();

    // Default-size node: px all zero so the result is the bias alone.
    begin
      exp_t e;
      e.out = 32'h0000_1000; e.sat = 1'b0; e.done_cyc = cyc + NB + 2;
      qB.push_back(e);
      bstart = cyc;
      startB = 1'b1;
      tick();
      startB = 1'b0;
    end
    for (int i = 0; i < NB + 20 && qB.size() != 0; i++) tick();
    repeat (5) tick();

    chk("queue4_drained", q4.size(), 0);
    chk("queueB_drained", qB.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
